button_debounce_array: RTL

// - Parametrised multi-channel debouncer for pong control buttons (paddle up/down,

---
 rtl/pong_input_pkg.sv | 16 +
 rtl/debounce_channel.sv | 174 +++++++++++++++++
 rtl/button_debounce_array.sv | 41 ++++
 3 files changed

// File: rtl/pong_input_pkg.sv
// Shared types and default timing for the pong button input path.
package pong_input_pkg;

  typedef enum logic [1:0] {
    REL_STABLE = 2'd0,
    PRESS_CHK  = 2'd1,
    PRS_STABLE = 2'd2,
    REL_CHK    = 2'd3
  } dbnc_state_t;

  localparam int unsigned DFLT_NUM_CH        = 4;
  localparam int unsigned DFLT_STABLE_CYCLES = 454545;
  localparam int unsigned DFLT_REPEAT_DELAY  = 25000000;
  localparam int unsigned DFLT_REPEAT_PERIOD = 5000000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-FF synchroniser, both-edge stable-time filter, press/release pulses.
// Hold auto-repeat is present only when BUTTON_REPEAT_EN is defined.
//
// state      | meaning
// REL_STABLE | debounced released, waiting for sync=1
// PRESS_CHK  | sync=1 seen, counting stable cycles before declaring press
// PRS_STABLE | debounced pressed, hold/repeat timer running
// REL_CHK    | sync=0 seen, counting stable cycles before declaring release
module debounce_channel
  import pong_input_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DFLT_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DFLT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DFLT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);

  logic          sync1_q, sync2_q;
  dbnc_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // cnt holds how many consecutive sync samples have shown the new level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      REL_STABLE: if (sync2_q) begin
        if (CNT_LAST == '0) begin
          state_d = PRS_STABLE;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = PRESS_CHK;
          cnt_d   = CW'(1);
        end
      end
      PRESS_CHK: begin
        if (!sync2_q) begin
          state_d = REL_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = PRS_STABLE;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRS_STABLE: if (!sync2_q) begin
        if (CNT_LAST == '0) begin
          state_d = REL_STABLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = REL_CHK;
          cnt_d   = CW'(1);
        end
      end
      REL_CHK: begin
        if (sync2_q) begin
          state_d = PRS_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = REL_STABLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = REL_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= REL_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef BUTTON_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(RPT_MAX + 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          first_q, first_d;
  logic          rpt_q, rpt_d;

  // first_q selects the initial delay; after a repeat or an aborted release check the period applies
  always_comb begin
    hold_d  = hold_q;
    first_d = first_q;
    rpt_d   = 1'b0;
    if (press_d) begin
      hold_d  = '0;
      first_d = 1'b1;
    end else if (state_q == PRS_STABLE && state_d == PRS_STABLE) begin
      if (hold_q == (first_q ? DLY_LAST : PER_LAST)) begin
        rpt_d   = 1'b1;
        hold_d  = '0;
        first_d = 1'b0;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end else begin
      hold_d  = '0;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      first_q <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      first_q <= first_d;
      rpt_q   <= rpt_d;
    end
  end

  assign repeat_o = rpt_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_array.sv
// NUM_CH independent button debouncers with optional active-low pin inversion.
// Define BUTTON_REPEAT_EN to enable hold auto-repeat on btn_repeat.
module button_debounce_array
  import pong_input_pkg::*;
#(
  parameter int unsigned NUM_CH        = DFLT_NUM_CH,
  parameter int unsigned STABLE_CYCLES = DFLT_STABLE_CYCLES,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter int unsigned REPEAT_DELAY  = DFLT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DFLT_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_repeat
);

  // Inverting ahead of the synchroniser keeps the reset value of the sync FFs meaning "released".
  logic [NUM_CH-1:0] btn_pol;
  assign btn_pol = ACTIVE_LOW ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (btn_pol[g]),
      .level_o  (btn_level[g]),
      .press_o  (btn_press[g]),
      .release_o(btn_release[g]),
      .repeat_o (btn_repeat[g])
    );
  end

endmodule
